// File: rtl/gate_sched_pkg.sv
// Shared types and helpers for the gate trigger scheduler.
package gate_sched_pkg;

  typedef enum logic [1:0] {IDLE, RUN, STALL, DRAIN} state_t;

  // $clog2 returns 0 for n<=1; a port still needs at least one bit.
  function automatic int clog2_min1(input int n);
    int r;
    r = $clog2(n);
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first set pending bit at or above rr_ptr, with wrap.
module rr_arbiter
  import gate_sched_pkg::*;
#(
  parameter int REQ_COUNT = 8,
  parameter int ID_W      = clog2_min1(REQ_COUNT)
) (
  input  logic [REQ_COUNT-1:0] pending,
  input  logic [ID_W-1:0]      rr_ptr,
  output logic                 grant_valid,
  output logic [ID_W-1:0]      grant_id
);

  logic [2*REQ_COUNT-1:0] doubled;
  logic [2*REQ_COUNT-1:0] masked;

  // Only the lower copy is masked, so the upper copy supplies the wrap-around candidates.
  always_comb begin
    doubled     = {pending, pending};
    masked      = doubled;
    grant_valid = 1'b0;
    grant_id    = '0;
    for (int j = 0; j < REQ_COUNT; j++) begin
      if (j < int'(rr_ptr)) masked[j] = 1'b0;
    end
    for (int j = 2*REQ_COUNT-1; j >= 0; j--) begin
      if (masked[j]) begin
        grant_valid = 1'b1;
        grant_id    = ID_W'((j >= REQ_COUNT) ? (j - REQ_COUNT) : j);
      end
    end
  end

endmodule

// File: rtl/gate_trigger_scheduler.sv
// Latches gate trigger requests, grants them round-robin onto one valid/ready port,
// and allows each gate to fire at most once per logic frame.
module gate_trigger_scheduler
  import gate_sched_pkg::*;
#(
  parameter int REQ_COUNT = 8,
  parameter int ID_W      = clog2_min1(REQ_COUNT),
  parameter int CNT_W     = clog2_min1(REQ_COUNT + 1)
) (
  input  logic                 clk,
  input  logic                 logic_reset,
  input  logic                 frame_start,
  input  logic [REQ_COUNT-1:0] req,
  output logic                 trig_valid,
  output logic [ID_W-1:0]      trig_id,
  input  logic                 trig_ready,
  output logic                 busy,
  output logic                 frame_done,
  output logic [CNT_W-1:0]     fire_count,
  output logic [CNT_W-1:0]     drop_count
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t                 state;
  state_t                 state_next;
  logic [REQ_COUNT-1:0]   pending;
  logic [REQ_COUNT-1:0]   fired;
  logic [REQ_COUNT-1:0]   fired_base;
  logic [REQ_COUNT-1:0]   grant_mask;
  logic [REQ_COUNT-1:0]   drop_mask;
  logic [ID_W-1:0]        rr_ptr;
  logic [ID_W-1:0]        winner;
  logic                   winner_valid;
  logic                   out_free;
  logic                   grant;
  logic                   transfer;
  logic [CNT_W:0]         drop_sum;

  rr_arbiter #(
    .REQ_COUNT (REQ_COUNT),
    .ID_W      (ID_W)
  ) u_arb (
    .pending     (pending),
    .rr_ptr      (rr_ptr),
    .grant_valid (winner_valid),
    .grant_id    (winner)
  );

  assign transfer   = trig_valid & trig_ready;
  assign fired_base = frame_start ? '0 : fired;
  assign grant_mask = grant ? (REQ_COUNT'(1) << winner) : '0;
  // A gate granted this cycle already counts as fired, so its own req is a drop.
  assign drop_mask  = req & (fired_base | grant_mask);
  assign busy       = (|pending) | trig_valid;

  // No grant during DRAIN: the frame_done cycle is kept free of new triggers.
  always_comb begin
    state_next = state;
    out_free   = (!trig_valid || trig_ready) && (state != DRAIN);
    grant      = out_free && winner_valid;
    frame_done = (state == DRAIN);
    if (grant)
      state_next = RUN;
    else if (transfer)
      state_next = frame_start ? IDLE : DRAIN;
    else if (trig_valid)
      state_next = STALL;
    else
      state_next = IDLE;
  end

  always_comb begin
    drop_sum = frame_start ? '0 : {1'b0, drop_count};
    for (int i = 0; i < REQ_COUNT; i++) begin
      if (drop_mask[i])
        drop_sum = (drop_sum >= {1'b0, CNT_MAX}) ? {1'b0, CNT_MAX} : drop_sum + (CNT_W+1)'(1);
    end
  end

  always_ff @(posedge clk or posedge logic_reset) begin
    if (logic_reset) begin
      state      <= IDLE;
      pending    <= '0;
      fired      <= '0;
      rr_ptr     <= '0;
      trig_valid <= 1'b0;
      trig_id    <= '0;
      fire_count <= '0;
      drop_count <= '0;
    end else begin
      state   <= state_next;
      pending <= (pending & ~grant_mask) | (req & ~(fired_base | grant_mask));
      fired   <= fired_base | grant_mask;
      if (grant) begin
        trig_valid <= 1'b1;
        trig_id    <= winner;
        rr_ptr     <= (winner == ID_W'(REQ_COUNT - 1)) ? '0 : winner + 1'b1;
      end else if (transfer) begin
        trig_valid <= 1'b0;
      end
      // A transfer coinciding with frame_start belongs to the frame that just ended.
      if (frame_start)
        fire_count <= '0;
      else if (transfer && fire_count != CNT_MAX)
        fire_count <= fire_count + 1'b1;
      drop_count <= drop_sum[CNT_W-1:0];
    end
  end

endmodule

// File: tb/tb_gate_trigger_scheduler.sv
// Self-checking bench: directed scenarios with literal expectations plus random traffic,
// all compared every cycle against a sequential behavioural model of the scheduler.
module tb_gate_trigger_scheduler;

  localparam int N     = 8;
  localparam int ID_W  = 3;
  localparam int CNT_W = 4;
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             logic_reset = 1'b1;
  logic             frame_start = 1'b0;
  logic [N-1:0]     req = '0;
  logic             trig_ready = 1'b0;
  logic             trig_valid;
  logic [ID_W-1:0]  trig_id;
  logic             busy;
  logic             frame_done;
  logic [CNT_W-1:0] fire_count;
  logic [CNT_W-1:0] drop_count;

  int checks   = 0;
  int failures = 0;

  gate_trigger_scheduler #(.REQ_COUNT(N)) dut (
    .clk         (clk),
    .logic_reset (logic_reset),
    .frame_start (frame_start),
    .req         (req),
    .trig_valid  (trig_valid),
    .trig_id     (trig_id),
    .trig_ready  (trig_ready),
    .busy        (busy),
    .frame_done  (frame_done),
    .fire_count  (fire_count),
    .drop_count  (drop_count)
  );

  always #5 clk = ~clk;

  // Behavioural model: gate-level bookkeeping with plain arrays and counters.
  bit m_pend [N];
  bit m_fired[N];
  int m_rr, m_id, m_fire, m_drop;
  bit m_valid, m_done;

  always @(posedge clk or posedge logic_reset) begin : model
    bit xfer, can_grant, any_pend;
    int win, idx;
    if (logic_reset) begin
      for (int i = 0; i < N; i++) begin
        m_pend[i]  = 1'b0;
        m_fired[i] = 1'b0;
      end
      m_rr = 0; m_id = 0; m_fire = 0; m_drop = 0;
      m_valid = 1'b0; m_done = 1'b0;
    end else begin
      xfer      = m_valid && trig_ready;
      can_grant = (!m_valid || trig_ready) && !m_done;
      any_pend  = 1'b0;
      win       = -1;
      for (int i = 0; i < N; i++) if (m_pend[i]) any_pend = 1'b1;
      if (can_grant) begin
        for (int k = 0; k < N; k++) begin
          idx = (m_rr + k) % N;
          if (win < 0 && m_pend[idx]) win = idx;
        end
      end
      if (frame_start) begin
        for (int i = 0; i < N; i++) m_fired[i] = 1'b0;
        m_fire = 0;
        m_drop = 0;
      end else if (xfer) begin
        m_fire = (m_fire < CMAX) ? m_fire + 1 : CMAX;
      end
      if (win >= 0) begin
        m_pend[win]  = 1'b0;
        m_fired[win] = 1'b1;
      end
      for (int i = 0; i < N; i++) begin
        if (req[i]) begin
          if (m_fired[i]) m_drop = (m_drop < CMAX) ? m_drop + 1 : CMAX;
          else            m_pend[i] = 1'b1;
        end
      end
      m_done = xfer && !any_pend && !frame_start;
      if (win >= 0) begin
        m_valid = 1'b1;
        m_id    = win;
        m_rr    = (win + 1) % N;
      end else if (xfer) begin
        m_valid = 1'b0;
      end
    end
  end

  task automatic check_output(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  function automatic int model_busy();
    int b;
    b = m_valid ? 1 : 0;
    for (int i = 0; i < N; i++) if (m_pend[i]) b = 1;
    return b;
  endfunction

  always @(negedge clk) begin
    if (!logic_reset) begin
      check_output("model.trig_valid", int'(trig_valid), int'(m_valid));
      check_output("model.trig_id",    int'(trig_id),    m_id);
      check_output("model.busy",       int'(busy),       model_busy());
      check_output("model.frame_done", int'(frame_done), int'(m_done));
      check_output("model.fire_count", int'(fire_count), m_fire);
      check_output("model.drop_count", int'(drop_count), m_drop);
    end
  end

  // Drives one cycle of inputs; returns 1 time unit after the edge that sampled them.
  task automatic apply_stimulus(input logic [N-1:0] r, input logic fs, input logic rdy);
    req         = r;
    frame_start = fs;
    trig_ready  = rdy;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    req = '0; frame_start = 1'b0; trig_ready = 1'b0;
    logic_reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    logic_reset = 1'b0;
  endtask

  initial begin
    // Reset state
    do_reset();
    check_output("reset.trig_valid", int'(trig_valid), 0);
    check_output("reset.trig_id",    int'(trig_id),    0);
    check_output("reset.busy",       int'(busy),       0);
    check_output("reset.frame_done", int'(frame_done), 0);
    check_output("reset.fire_count", int'(fire_count), 0);
    check_output("reset.drop_count", int'(drop_count), 0);

    // Single request: valid two edges after req, frame_done on the following one
    apply_stimulus(8'h04, 1'b0, 1'b1);
    check_output("single.k1_valid", int'(trig_valid), 0);
    apply_stimulus(8'h00, 1'b0, 1'b1);
    check_output("single.valid", int'(trig_valid), 1);
    check_output("single.id",    int'(trig_id),    2);
    apply_stimulus(8'h00, 1'b0, 1'b1);
    check_output("single.fire_count", int'(fire_count), 1);
    check_output("single.frame_done", int'(frame_done), 1);
    check_output("single.valid_off",  int'(trig_valid), 0);
    apply_stimulus(8'h00, 1'b0, 1'b1);
    check_output("single.done_pulse", int'(frame_done), 0);

    // Round-robin order
    do_reset();
    apply_stimulus(8'hFF, 1'b0, 1'b1);
    for (int k = 0; k < N; k++) begin
      apply_stimulus(8'h00, 1'b0, 1'b1);
      check_output("rr.valid", int'(trig_valid), 1);
      check_output("rr.id",    int'(trig_id),    k);
    end
    apply_stimulus(8'h00, 1'b0, 1'b1);
    check_output("rr.fire_count", int'(fire_count), 8);
    check_output("rr.frame_done", int'(frame_done), 1);
    apply_stimulus(8'h81, 1'b1, 1'b1);
    check_output("rr.fs_fire_clear", int'(fire_count), 0);
    apply_stimulus(8'h00, 1'b0, 1'b1);
    check_output("rr.wrap_first", int'(trig_id), 0);
    apply_stimulus(8'h00, 1'b0, 1'b1);
    check_output("rr.wrap_second", int'(trig_id), 7);
    apply_stimulus(8'h00, 1'b0, 1'b1);
    apply_stimulus(8'h00, 1'b1, 1'b1);
    apply_stimulus(8'h01, 1'b0, 1'b1);
    apply_stimulus(8'h00, 1'b0, 1'b1);
    apply_stimulus(8'h00, 1'b0, 1'b1);
    apply_stimulus(8'h81, 1'b1, 1'b1);
    apply_stimulus(8'h00, 1'b0, 1'b1);
    check_output("rr.ptr1_first", int'(trig_id), 7);
    apply_stimulus(8'h00, 1'b0, 1'b1);
    check_output("rr.ptr1_second", int'(trig_id), 0);

    // Backpressure holds trig_id
    do_reset();
    apply_stimulus(8'h06, 1'b0, 1'b0);
    apply_stimulus(8'h00, 1'b0, 1'b0);
    for (int k = 0; k < 5; k++) begin
      apply_stimulus(8'h00, 1'b0, 1'b0);
      check_output("bp.valid", int'(trig_valid), 1);
      check_output("bp.id",    int'(trig_id),    1);
    end
    apply_stimulus(8'h00, 1'b0, 1'b1);
    check_output("bp.next_id", int'(trig_id), 2);
    apply_stimulus(8'h00, 1'b0, 1'b1);
    check_output("bp.fire_count", int'(fire_count), 2);

    // Once per frame
    do_reset();
    apply_stimulus(8'h08, 1'b0, 1'b1);
    apply_stimulus(8'h00, 1'b0, 1'b1);
    apply_stimulus(8'h00, 1'b0, 1'b1);
    apply_stimulus(8'h08, 1'b0, 1'b1);
    check_output("once.drop_count", int'(drop_count), 1);
    apply_stimulus(8'h00, 1'b0, 1'b1);
    check_output("once.no_refire", int'(trig_valid), 0);
    apply_stimulus(8'h00, 1'b1, 1'b1);
    check_output("once.drop_clear", int'(drop_count), 0);
    apply_stimulus(8'h08, 1'b0, 1'b1);
    apply_stimulus(8'h00, 1'b0, 1'b1);
    check_output("once.refire_valid", int'(trig_valid), 1);
    check_output("once.refire_id",    int'(trig_id),    3);

    // frame_start coincident with a transfer and req[5]
    do_reset();
    apply_stimulus(8'h01, 1'b0, 1'b0);
    apply_stimulus(8'h00, 1'b0, 1'b0);
    apply_stimulus(8'h20, 1'b1, 1'b1);
    check_output("fsx.fire_count", int'(fire_count), 0);
    check_output("fsx.frame_done", int'(frame_done), 0);
    check_output("fsx.busy",       int'(busy),       1);
    apply_stimulus(8'h00, 1'b0, 1'b1);
    check_output("fsx.valid", int'(trig_valid), 1);
    check_output("fsx.id",    int'(trig_id),    5);

    // Asynchronous reset with a trigger presented and pending=F0
    do_reset();
    apply_stimulus(8'hF1, 1'b0, 1'b0);
    apply_stimulus(8'h00, 1'b0, 1'b0);
    check_output("areset.pre_valid", int'(trig_valid), 1);
    #2 logic_reset = 1'b1;
    #1;
    check_output("areset.valid", int'(trig_valid), 0);
    check_output("areset.busy",  int'(busy),       0);
    check_output("areset.id",    int'(trig_id),    0);
    @(posedge clk);
    #1 logic_reset = 1'b0;
    for (int k = 0; k < 4; k++) begin
      apply_stimulus(8'h00, 1'b0, 1'b1);
      check_output("areset.quiet", int'(trig_valid), 0);
    end

    // Random traffic against the model
    for (int c = 0; c < 2000; c++) begin
      logic [N-1:0] r;
      r = ($urandom_range(0, 3) == 0) ? (N'($urandom) & N'($urandom)) : '0;
      apply_stimulus(r, ($urandom_range(0, 24) == 0), ($urandom_range(0, 9) < 7));
      if (c % 700 == 350) do_reset();
    end

    apply_stimulus(8'h00, 1'b0, 1'b1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
